pc_unit: RTL and testbench
==========================

# pc_unit

Parametrised fetch-stage program counter for the pipelined MIPS core; the successor to the single-cycle PC. Holds the fetch address and advances it on `pc_next`. Accepts branch/jump/jr redirects resolved later in the pipeline, and holds a redirect that arrives during a fetch stall until the stall clears. Optionally predicts taken control flow through a direct-mapped branch target buffer (BTB) at fetch.

## Interface
- `PC_INIT`, 32'h0000_0000, fetch address after reset
- `BTB_DEPTH`, 8, BTB entries; power of two, 2..64; unused unless `PC_BTB_EN`
- `CLK`  in  1  clock, rising edge
- `RST`  in  1  reset, asynchronous, active-high
- `pc_next`  in  1  fetch may advance (ihit and no stall)
- `redirect_valid`  in  1  control-flow outcome presented this cycle
- `redirect_src`  in  2  PCSrc_t: 0 SEQ, 1 BR, 2 J, 3 JR
- `redirect_base`  in  32  PC of the resolving instruction
- `imm16`  in  16  branch offset, in words
- `j_addr26`  in  26  jump field
- `jr`  in  32  register target (word_t)
- `i_addr`  out  32  current fetch address (registered)
- `npc`  out  32  `i_addr + 4`, combinational
- `pred_taken`  out  1  `i_addr` hits the BTB and the BTB supplies the next address
- `flush`  out  1  `i_addr` was loaded from a redirect on the last edge

## Operation
- Target computation, 32-bit, wrap modulo 2^32, with `b4 = redirect_base + 4`:
  - SEQ: `b4`
  - BR: `b4 + (sext(imm16) << 2)`
  - J: `{b4[31:28], j_addr26, 2'b00}`
  - JR: `jr` as given; no alignment check.
- Pending register: `pend_valid` plus a 32-bit `pend_target`.
  - A redirect with `pc_next`=0 loads the pending register.
  - A newer redirect while pending overwrites it.
- Next-address priority, applied only when `pc_next`=1:
  1. Live redirect target.
  2. `pend_target`.
  3. BTB target on a hit.
  4. `npc`.
- Applying a live redirect or a pending target clears `pend_valid`.
- `pc_next`=0: `i_addr` holds; only the pending register and the BTB update.
- BTB (`PC_BTB_EN` only):
  - Entry format: `{valid, tag = addr[31:2+log2(BTB_DEPTH)], target}`.
  - Index: `addr[2+log2(BTB_DEPTH)-1:2]`.
  - Lookup is combinational on `i_addr`. Hit means valid and tag equal.
  - Every `redirect_valid` writes at the index/tag of `redirect_base`, independent of `pc_next`:
    - BR, J, JR: write the computed target and set valid.
    - SEQ: clear valid (not-taken correction).
  - Write takes effect at the edge. A same-cycle lookup on that index sees the old contents.
- `pred_taken` = hit and no live or pending redirect.

## Timing
- Reset (async, immediate):
  - `i_addr`=`PC_INIT`, `npc`=`PC_INIT+4`.
  - `flush`=0, `pred_taken`=0.
  - `pend_valid`=0 and all BTB valid bits=0.
- Redirect latency: presented in cycle N with `pc_next`=1, the target appears on `i_addr` in cycle N+1, with `flush`=1 for exactly that cycle.
- Stalled redirect: the target appears the cycle after the first cycle with `pc_next`=1; `flush` pulses then.
- BTB-predicted advance: the target appears on `i_addr` the next cycle; no `flush`.
- `RST` asserted mid-stall discards the pending redirect.

## Configuration
- `PC_BTB_EN` defined: BTB built per Operation.
- `PC_BTB_EN` undefined:
  - No BTB storage.
  - `pred_taken` is tied 0.
  - Priority reduces to live redirect, then pending, then `npc`.
  - SEQ redirects still redirect fetch.

## Test plan
- Reset, then `pc_next`=1 for 3 cycles -> `i_addr` sequence 0x0, 0x4, 0x8, 0xC; `flush`=0 throughout.
- BR with base 0x100, imm16=0xFFFE, `pc_next`=1 -> next `i_addr`=0xFC and `flush`=1 for one cycle.
- J with base 0xF000_0010, j_addr26=0x40 -> `i_addr`=0xF000_0100. JR with jr=0x0000_2000 -> `i_addr`=0x2000.
- Stall wrap:
  - `pc_next`=0 with JR 0x400 presented.
  - Then JR 0x800 two cycles later while still stalled.
  - Then `pc_next`=1 -> `i_addr`=0x800 one cycle later, `flush`=1 once.
  - `i_addr` constant during the stall.
- `PC_BTB_EN`, depth 8:
  - BR from base 0x20 to 0x80.
  - Refetch 0x20 -> `pred_taken`=1; next `i_addr`=0x80 with no `flush`.
  - SEQ redirect for base 0x20 -> the next fetch of 0x20 gives `pred_taken`=0 and next address 0x24.
- Aliasing and reset:
  - Entry for 0x20, then fetch 0x40 (same index, different tag) -> `pred_taken`=0.
  - Assert `RST` with an entry valid -> after release, 0x20 misses.

Source files
------------

// File: rtl/pc_if.sv
// Fetch-PC bus: redirect request from the pipeline plus the fetch-address outputs.
// The pipeline side drives through master; pc_unit attaches through slave.
interface pc_if;
  logic        pc_next;
  logic        redirect_valid;
  logic [1:0]  redirect_src;
  logic [31:0] redirect_base;
  logic [15:0] imm16;
  logic [25:0] j_addr26;
  logic [31:0] jr;
  logic [31:0] i_addr;
  logic [31:0] npc;
  logic        pred_taken;
  logic        flush;

  modport master (
    output pc_next, redirect_valid, redirect_src, redirect_base, imm16, j_addr26, jr,
    input  i_addr, npc, pred_taken, flush
  );

  modport slave (
    input  pc_next, redirect_valid, redirect_src, redirect_base, imm16, j_addr26, jr,
    output i_addr, npc, pred_taken, flush
  );
endinterface

// File: rtl/pc_unit.sv
// Fetch-stage program counter with held redirects and an optional direct-mapped BTB.
// Define PC_BTB_EN to build the BTB; without it, pred_taken is tied low.
module pc_unit #(
  parameter logic [31:0] PC_INIT   = 32'h0000_0000,
  parameter int          BTB_DEPTH = 8
) (
  input logic CLK,
  input logic RST,
  pc_if.slave bus
);

  typedef enum logic [1:0] {
    SRC_SEQ = 2'd0,
    SRC_BR  = 2'd1,
    SRC_J   = 2'd2,
    SRC_JR  = 2'd3
  } pc_src_e;

  if ((BTB_DEPTH < 2) || (BTB_DEPTH > 64) || ((BTB_DEPTH & (BTB_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("pc_unit: BTB_DEPTH must be a power of two in 2..64");
  end

  pc_src_e     src;
  logic [31:0] b4;
  logic [31:0] target;
  logic [31:0] next_addr;
  logic [31:0] i_addr_q;
  logic        flush_q;
  logic        pend_valid;
  logic [31:0] pend_target;
  logic        btb_hit;
  logic [31:0] btb_target;

  assign src = pc_src_e'(bus.redirect_src);

  always_comb begin
    b4     = bus.redirect_base + 32'd4;
    target = b4;
    case (src)
      SRC_SEQ: target = b4;
      SRC_BR:  target = b4 + {{14{bus.imm16[15]}}, bus.imm16, 2'b00};
      SRC_J:   target = {b4[31:28], bus.j_addr26, 2'b00};
      SRC_JR:  target = bus.jr;
      default: target = b4;
    endcase
  end

  // A live redirect outranks a held one, which outranks a BTB prediction.
  always_comb begin
    next_addr = i_addr_q + 32'd4;
    if (bus.redirect_valid)  next_addr = target;
    else if (pend_valid)     next_addr = pend_target;
    else if (btb_hit)        next_addr = btb_target;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      i_addr_q    <= PC_INIT;
      flush_q     <= 1'b0;
      pend_valid  <= 1'b0;
      pend_target <= 32'd0;
    end else if (bus.pc_next) begin
      i_addr_q   <= next_addr;
      flush_q    <= bus.redirect_valid | pend_valid;
      pend_valid <= 1'b0;
    end else begin
      flush_q <= 1'b0;
      if (bus.redirect_valid) begin
        pend_valid  <= 1'b1;
        pend_target <= target;
      end
    end
  end

`ifdef PC_BTB_EN
  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = 30 - IDX_W;

  logic [BTB_DEPTH-1:0] btb_valid;
  logic [TAG_W-1:0]     btb_tag [BTB_DEPTH];
  logic [31:0]          btb_tgt [BTB_DEPTH];
  logic [IDX_W-1:0]     rd_idx;
  logic [IDX_W-1:0]     wr_idx;
  logic [TAG_W-1:0]     rd_tag;
  logic [TAG_W-1:0]     wr_tag;

  assign rd_idx     = i_addr_q[IDX_W+1:2];
  assign rd_tag     = i_addr_q[31:IDX_W+2];
  assign wr_idx     = bus.redirect_base[IDX_W+1:2];
  assign wr_tag     = bus.redirect_base[31:IDX_W+2];
  assign btb_hit    = btb_valid[rd_idx] && (btb_tag[rd_idx] == rd_tag);
  assign btb_target = btb_tgt[rd_idx];

  // Resolved SEQ outcomes drop the entry so a not-taken branch stops predicting.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) btb_valid <= '0;
    else if (bus.redirect_valid) btb_valid[wr_idx] <= (src != SRC_SEQ);
  end

  // NOTE: only the valid bits are reset; tag/target payload is never read
  // while its valid bit is clear, so it stays reset-free storage.
  always_ff @(posedge CLK) begin
    if (bus.redirect_valid && (src != SRC_SEQ)) begin
      btb_tag[wr_idx] <= wr_tag;
      btb_tgt[wr_idx] <= target;
    end
  end
`else
  assign btb_hit    = 1'b0;
  assign btb_target = 32'd0;
`endif

  assign bus.i_addr     = i_addr_q;
  assign bus.npc        = i_addr_q + 32'd4;
  assign bus.flush      = flush_q;
  assign bus.pred_taken = btb_hit && !bus.redirect_valid && !pend_valid;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: vector table, hand-written corner sequences and
// random traffic against an address-level reference model (BTB checks need PC_BTB_EN).
module tb_pc_unit;
  localparam logic [31:0] PC_INIT = 32'h0000_0000;
  localparam int          DEPTH   = 8;
`ifdef PC_BTB_EN
  localparam bit BTB_ON = 1'b1;
`else
  localparam bit BTB_ON = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST;
  pc_if bus();

  pc_unit #(.PC_INIT(PC_INIT), .BTB_DEPTH(DEPTH)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: fetch address, held redirect, and BTB entries keyed by slot
  // holding the full resolving address and its taken target.
  logic [31:0] m_pc;
  bit          m_pv;
  logic [31:0] m_pt;
  logic [31:0] m_btb_base [int];
  logic [31:0] m_btb_tgt  [int];

  function automatic int slot(input logic [31:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    if (!BTB_ON || !m_btb_base.exists(slot(a))) return 1'b0;
    return (m_btb_base[slot(a)] / (4 * DEPTH)) == (a / (4 * DEPTH));
  endfunction

  function automatic logic [31:0] m_target(input logic [1:0] src, input logic [31:0] base,
                                           input logic [15:0] imm, input logic [25:0] j,
                                           input logic [31:0] jr);
    logic [31:0] b4;
    logic [31:0] off;
    b4  = base + 32'd4;
    off = 32'($signed(imm)) * 4;
    case (src)
      2'd1:    return b4 + off;
      2'd2:    return (b4 & 32'hF000_0000) | (32'(j) * 4);
      2'd3:    return jr;
      default: return b4;
    endcase
  endfunction

  task automatic model_reset();
    m_pc = PC_INIT;
    m_pv = 1'b0;
    m_pt = 32'd0;
    m_btb_base.delete();
    m_btb_tgt.delete();
  endtask

  task automatic drive(input bit pn, input bit rv, input logic [1:0] src, input logic [31:0] base,
                       input logic [15:0] imm, input logic [25:0] j, input logic [31:0] jr);
    bus.pc_next        = pn;
    bus.redirect_valid = rv;
    bus.redirect_src   = src;
    bus.redirect_base  = base;
    bus.imm16          = imm;
    bus.j_addr26       = j;
    bus.jr             = jr;
  endtask

  // One clock: check combinational outputs, advance the model, then check registered outputs.
  bit m_flush;
  task automatic tick(input string tag);
    logic [31:0] tgt;
    bit          hit;
    #1;
    hit = m_hit(m_pc);
    tgt = m_target(bus.redirect_src, bus.redirect_base, bus.imm16, bus.j_addr26, bus.jr);
    check({tag, ".npc"}, bus.npc, m_pc + 32'd4);
    check({tag, ".pred_taken"}, 32'(bus.pred_taken), 32'(hit && !bus.redirect_valid && !m_pv));
    m_flush = 1'b0;
    if (bus.pc_next) begin
      if (bus.redirect_valid) begin m_pc = tgt; m_flush = 1'b1; end
      else if (m_pv)          begin m_pc = m_pt; m_flush = 1'b1; end
      else if (hit)           m_pc = m_btb_tgt[slot(m_pc)];
      else                    m_pc = m_pc + 32'd4;
      m_pv = 1'b0;
    end else if (bus.redirect_valid) begin
      m_pv = 1'b1;
      m_pt = tgt;
    end
    if (BTB_ON && bus.redirect_valid) begin
      if (bus.redirect_src == 2'd0) begin
        m_btb_base.delete(slot(bus.redirect_base));
        m_btb_tgt.delete(slot(bus.redirect_base));
      end else begin
        m_btb_base[slot(bus.redirect_base)] = bus.redirect_base;
        m_btb_tgt[slot(bus.redirect_base)]  = tgt;
      end
    end
    @(posedge CLK);
    #1;
    check({tag, ".i_addr"}, bus.i_addr, m_pc);
    check({tag, ".flush"}, 32'(bus.flush), 32'(m_flush));
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 2'd0, 32'd0, 16'd0, 26'd0, 32'd0);
    RST = 1'b1;
    #1;
    model_reset();
    check("rst.i_addr", bus.i_addr, PC_INIT);
    check("rst.npc", bus.npc, PC_INIT + 32'd4);
    check("rst.flush", 32'(bus.flush), 32'd0);
    check("rst.pred_taken", 32'(bus.pred_taken), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  typedef struct {
    bit          pn;
    bit          rv;
    logic [1:0]  src;
    logic [31:0] base;
    logic [15:0] imm;
    logic [25:0] j;
    logic [31:0] jr;
    logic [31:0] exp_addr;
    bit          exp_flush;
  } vec_t;

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{1, 0, 2'd0, 32'h0,         16'h0,    26'h0,  32'h0,    32'h0000_0004, 0};
    vecs[1]  = '{1, 0, 2'd0, 32'h0,         16'h0,    26'h0,  32'h0,    32'h0000_0008, 0};
    vecs[2]  = '{1, 0, 2'd0, 32'h0,         16'h0,    26'h0,  32'h0,    32'h0000_000C, 0};
    vecs[3]  = '{1, 1, 2'd1, 32'h100,       16'hFFFE, 26'h0,  32'h0,    32'h0000_00FC, 1};
    vecs[4]  = '{1, 0, 2'd0, 32'h0,         16'h0,    26'h0,  32'h0,    32'h0000_0100, 0};
    vecs[5]  = '{1, 1, 2'd2, 32'hF000_0010, 16'h0,    26'h40, 32'h0,    32'hF000_0100, 1};
    vecs[6]  = '{1, 1, 2'd3, 32'h3000,      16'h0,    26'h0,  32'h2000, 32'h0000_2000, 1};
    vecs[7]  = '{1, 0, 2'd0, 32'h0,         16'h0,    26'h0,  32'h0,    32'h0000_2004, 0};
    vecs[8]  = '{0, 0, 2'd0, 32'h0,         16'h0,    26'h0,  32'h0,    32'h0000_2004, 0};
    vecs[9]  = '{1, 1, 2'd0, 32'h500,       16'h0,    26'h0,  32'h0,    32'h0000_0504, 1};
    vecs[10] = '{1, 0, 2'd0, 32'h0,         16'h0,    26'h0,  32'h0,    32'h0000_0508, 0};

    do_reset();

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].pn, vecs[i].rv, vecs[i].src, vecs[i].base, vecs[i].imm, vecs[i].j, vecs[i].jr);
      tick($sformatf("vec%0d", i));
      check($sformatf("vec%0d.tbl_addr", i), bus.i_addr, vecs[i].exp_addr);
      check($sformatf("vec%0d.tbl_flush", i), 32'(bus.flush), 32'(vecs[i].exp_flush));
    end

    // Two redirects arrive during a stall; only the newer one is applied.
    drive(0, 1, 2'd3, 32'h600, 16'h0, 26'h0, 32'h400);
    tick("stall0");
    check("stall0.hold", bus.i_addr, 32'h508);
    drive(0, 0, 2'd0, 32'h0, 16'h0, 26'h0, 32'h0);
    tick("stall1");
    check("stall1.hold", bus.i_addr, 32'h508);
    drive(0, 1, 2'd3, 32'h600, 16'h0, 26'h0, 32'h800);
    tick("stall2");
    check("stall2.hold", bus.i_addr, 32'h508);
    drive(1, 0, 2'd0, 32'h0, 16'h0, 26'h0, 32'h0);
    tick("stall_release");
    check("stall_release.addr", bus.i_addr, 32'h800);
    check("stall_release.flush", 32'(bus.flush), 32'd1);
    tick("stall_after");
    check("stall_after.addr", bus.i_addr, 32'h804);
    check("stall_after.flush", 32'(bus.flush), 32'd0);

    // Reset asserted while a redirect is held discards it.
    drive(0, 1, 2'd3, 32'h700, 16'h0, 26'h0, 32'h4000);
    tick("rst_stall");
    do_reset();
    drive(1, 0, 2'd0, 32'h0, 16'h0, 26'h0, 32'h0);
    tick("rst_stall_after");
    check("rst_stall_after.addr", bus.i_addr, PC_INIT + 32'd4);
    check("rst_stall_after.flush", 32'(bus.flush), 32'd0);

`ifdef PC_BTB_EN
    do_reset();
    drive(1, 1, 2'd1, 32'h20, 16'h0017, 26'h0, 32'h0);
    tick("btb_train");
    check("btb_train.addr", bus.i_addr, 32'h80);
    drive(1, 1, 2'd3, 32'h14, 16'h0, 26'h0, 32'h20);
    tick("btb_refetch");
    drive(1, 1, 2'd3, 32'h14, 16'h0, 26'h0, 32'h20);
    #1;
    check("btb_live_redirect_masks_pred", 32'(bus.pred_taken), 32'd0);
    tick("btb_refetch2");
    drive(1, 0, 2'd0, 32'h0, 16'h0, 26'h0, 32'h0);
    #1;
    check("btb_hit.pred_taken", 32'(bus.pred_taken), 32'd1);
    tick("btb_pred");
    check("btb_pred.addr", bus.i_addr, 32'h80);
    check("btb_pred.flush", 32'(bus.flush), 32'd0);
    drive(1, 1, 2'd0, 32'h20, 16'h0, 26'h0, 32'h0);
    tick("btb_seq_clear");
    drive(1, 1, 2'd3, 32'h14, 16'h0, 26'h0, 32'h20);
    tick("btb_refetch3");
    drive(1, 0, 2'd0, 32'h0, 16'h0, 26'h0, 32'h0);
    #1;
    check("btb_cleared.pred_taken", 32'(bus.pred_taken), 32'd0);
    tick("btb_cleared");
    check("btb_cleared.addr", bus.i_addr, 32'h24);

    // Alias: 0x40 shares the slot of 0x20 with a different tag.
    drive(1, 1, 2'd1, 32'h20, 16'h0017, 26'h0, 32'h0);
    tick("alias_train");
    drive(1, 1, 2'd3, 32'h14, 16'h0, 26'h0, 32'h40);
    tick("alias_jump");
    drive(1, 0, 2'd0, 32'h0, 16'h0, 26'h0, 32'h0);
    #1;
    check("alias.pred_taken", 32'(bus.pred_taken), 32'd0);
    tick("alias_step");
    check("alias.addr", bus.i_addr, 32'h44);

    // Entry for 0x20 is valid again; reset must invalidate it.
    drive(1, 1, 2'd3, 32'h14, 16'h0, 26'h0, 32'h20);
    tick("btbrst_jump");
    do_reset();
    drive(1, 1, 2'd3, 32'h14, 16'h0, 26'h0, 32'h20);
    tick("btbrst_refetch");
    drive(1, 0, 2'd0, 32'h0, 16'h0, 26'h0, 32'h0);
    #1;
    check("btbrst.pred_taken", 32'(bus.pred_taken), 32'd0);
    tick("btbrst_step");
    check("btbrst.addr", bus.i_addr, 32'h24);
`endif

    // Random traffic confined to a small address window so the BTB sees hits and aliases.
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      logic [15:0] imm;
      logic [31:0] base;
      base = 32'($urandom_range(0, 63)) * 4;
      imm  = 16'($urandom_range(0, 64)) - 16'd32;
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)),
            base, imm, 26'($urandom_range(0, 63)), 32'($urandom_range(0, 255)));
      tick("rand");
      if ((m_pc > 32'h400) && !bus.redirect_valid) begin
        drive(1, 1, 2'd3, base, 16'h0, 26'h0, 32'($urandom_range(0, 63)) * 4);
        tick("rand_pull");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
